// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader and the fetch path.
// Holds the loader state encoding and the instruction byte-order convention.
// No logic; constants and a helper only.
package prog_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } load_state_e;

    // Instruction byte [REG_BITS-1 -: 8] sits at the lowest address; fetch
    // reassembles words with the same convention.
    localparam bit BYTE_ORDER_BIG_ENDIAN = 1'b1;

    // Bytes per instruction for a given register width (16 or 32).
    function automatic int instr_bytes(input int reg_bits);
        return reg_bits / 8;
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Streams a program byte-wise into instruction memory and holds the core until it is complete.
// Latency: accepted byte -> imem write 1 cycle; final byte -> done/error 2 cycles.
// Backpressure: byte_ready is high only while loading and drops right after the final/overflow byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int REG_BITS   = 32,
    parameter int IMEM_BYTES = 64,
    parameter int ADDR_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 byte_last,
    output logic                 byte_ready,
    output logic                 imem_we,
    output logic [ADDR_BITS-1:0] imem_addr,
    output logic [7:0]           imem_wdata,
    output logic                 core_run,
    output logic                 done,
    output logic                 error,
    output logic [ADDR_BITS-1:0] instr_count
);

    localparam int INSTR_BYTES = instr_bytes(REG_BITS);
    localparam int IB_LOG2     = $clog2(INSTR_BYTES);
    // Counter is one bit wider than the address so a full memory (IMEM_BYTES) is representable.
    localparam logic [ADDR_BITS:0] LAST_CNT = (ADDR_BITS + 1)'(IMEM_BYTES - 1);
    localparam logic [ADDR_BITS:0] CNT_ONE  = (ADDR_BITS + 1)'(1);

    load_state_e          state_q, state_d;
    logic [ADDR_BITS:0]   cnt_q, cnt_d;
    logic                 fin_q, fin_d;           // final/overflow byte written, length check pending
    logic                 fin_last_q, fin_last_d; // that byte carried byte_last
    logic                 byte_ready_q, byte_ready_d;
    logic                 imem_we_q, imem_we_d;
    logic [ADDR_BITS-1:0] imem_addr_q, imem_addr_d;
    logic [7:0]           imem_wdata_q, imem_wdata_d;
    logic                 core_run_q, core_run_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic [ADDR_BITS-1:0] instr_count_q, instr_count_d;

    logic                 accept;
    logic [ADDR_BITS:0]   words;

    assign accept = byte_valid && byte_ready_q;
    assign words  = cnt_q >> IB_LOG2;

    // Next-state, write-register and status computation
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        fin_d         = fin_q;
        fin_last_d    = fin_last_q;
        byte_ready_d  = byte_ready_q;
        imem_we_d     = 1'b0;
        imem_addr_d   = imem_addr_q;
        imem_wdata_d  = imem_wdata_q;
        core_run_d    = core_run_q;
        done_d        = done_q;
        error_d       = error_q;
        instr_count_d = instr_count_q;

        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d      = ST_LOAD;
                    cnt_d        = '0;
                    fin_d        = 1'b0;
                    fin_last_d   = 1'b0;
                    byte_ready_d = 1'b1;
                    core_run_d   = 1'b0;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                end
            end
            ST_LOAD: begin
                if (fin_q) begin
                    // The final write is on the bus this cycle; cnt_q now holds the total length.
                    fin_d = 1'b0;
                    if (fin_last_q && (cnt_q[IB_LOG2-1:0] == '0)) begin
                        state_d       = ST_DONE;
                        done_d        = 1'b1;
                        core_run_d    = 1'b1;
                        instr_count_d = words[ADDR_BITS-1:0];
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end else if (accept) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = cnt_q[ADDR_BITS-1:0];
                    imem_wdata_d = byte_data;
                    cnt_d        = cnt_q + CNT_ONE;
                    // Stop accepting on the last byte or on the top address so the address never wraps.
                    if (byte_last || (cnt_q == LAST_CNT)) begin
                        byte_ready_d = 1'b0;
                        fin_d        = 1'b1;
                        fin_last_d   = byte_last;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset cancels any pending write strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            fin_q         <= 1'b0;
            fin_last_q    <= 1'b0;
            byte_ready_q  <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            core_run_q    <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            instr_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fin_q         <= fin_d;
            fin_last_q    <= fin_last_d;
            byte_ready_q  <= byte_ready_d;
            imem_we_q     <= imem_we_d;
            imem_addr_q   <= imem_addr_d;
            imem_wdata_q  <= imem_wdata_d;
            core_run_q    <= core_run_d;
            done_q        <= done_d;
            error_q       <= error_d;
            instr_count_q <= instr_count_d;
        end
    end

    assign byte_ready  = byte_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign core_run    = core_run_q;
    assign done        = done_q;
    assign error       = error_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: expected imem writes are queued as bytes are accepted
// and checked by a write monitor; status outputs are checked inline per scenario.
module tb_prog_loader;

    localparam int AB = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_last = 1'b0;
    logic          byte_ready;
    logic          imem_we;
    logic [AB-1:0] imem_addr;
    logic [7:0]    imem_wdata;
    logic          core_run;
    logic          done;
    logic          error;
    logic [AB-1:0] instr_count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [AB-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t           exp_q[$];
    logic [AB-1:0] exp_addr = '0;

    prog_loader #(.REG_BITS(32), .IMEM_BYTES(64), .ADDR_BITS(AB)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_last   (byte_last),
        .byte_ready  (byte_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_run    (core_run),
        .done        (done),
        .error       (error),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (!reset && imem_we) begin
            wr_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%02h, required no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             imem_addr, imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_addr = '0;
    endtask

    // Present one byte, wait (bounded) for acceptance, queue the expected write.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        while (!byte_ready && n < 50) begin
            tick();
            n++;
        end
        if (!byte_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: byte_ready=%0b after %0d cycles, required 1", byte_ready, n);
        end else begin
            exp_q.push_back('{addr: exp_addr, data: d});
            exp_addr = exp_addr + 1'b1;
            tick();
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic check_drained(input string name);
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes_missing: %0d outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Called right after the final byte's accepting edge: status must flip one edge later.
    task automatic check_finish(input string name, input logic exp_done, input logic [AB-1:0] exp_cnt);
        checks++;
        if (done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL %s_early: done=%0b error=%0b during write cycle, required 0 0", name, done, error);
        end
        tick();
        checks++;
        if (done !== exp_done || error !== !exp_done || core_run !== exp_done || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_status: done=%0b error=%0b core_run=%0b byte_ready=%0b, required %0b %0b %0b 0",
                     name, done, error, core_run, byte_ready, exp_done, !exp_done, exp_done);
        end
        checks++;
        if (instr_count !== exp_cnt) begin
            errors++;
            $display("FAIL %s_instr_count: got %0d, required %0d", name, instr_count, exp_cnt);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (byte_ready !== 1'b0 || imem_we !== 1'b0 || core_run !== 1'b0 || done !== 1'b0 ||
            error !== 1'b0 || imem_addr !== '0 || imem_wdata !== 8'h00 || instr_count !== '0) begin
            errors++;
            $display("FAIL %s: rdy=%0b we=%0b run=%0b done=%0b err=%0b addr=%0d wdata=%02h cnt=%0d, required all 0",
                     name, byte_ready, imem_we, core_run, done, error, imem_addr, imem_wdata, instr_count);
        end
    endtask

    task automatic test_reset();
        #1;
        check_reset_outputs("reset_state");
        tick();
        reset = 1'b0;
        // Bytes offered in IDLE must be ignored
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        repeat (3) tick();
        byte_valid = 1'b0;
        check_reset_outputs("idle_ignores_bytes");
    endtask

    task automatic test_misaligned();
        pulse_start();
        checks++;
        if (byte_ready !== 1'b1 || core_run !== 1'b0) begin
            errors++;
            $display("FAIL load_entry: byte_ready=%0b core_run=%0b, required 1 0", byte_ready, core_run);
        end
        for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), i == 4);
        check_finish("misaligned", 1'b0, 6'd0);
        check_drained("misaligned");
    endtask

    task automatic test_load16();
        logic [7:0] prog [16];
        prog = '{8'h2B, 8'hFF, 8'hFF, 8'hFC, 8'h3C, 8'h00, 8'h00, 8'h00,
                 8'h04, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00};
        pulse_start();
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL start_clears_error: got %0b, required 0", error);
        end
        for (int i = 0; i < 16; i++) send_byte(prog[i], i == 15);
        check_finish("load16", 1'b1, 6'd4);
        check_drained("load16");
    endtask

    task automatic test_overflow();
        pulse_start();
        for (int i = 0; i < 64; i++) send_byte(8'(i * 3 + 1), 1'b0);
        check_finish("overflow", 1'b0, 6'd4);
        // Further bytes must be refused and must not wrap to address 0
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        repeat (4) tick();
        byte_valid = 1'b0;
        checks++;
        if (byte_ready !== 1'b0 || error !== 1'b1) begin
            errors++;
            $display("FAIL overflow_hold: byte_ready=%0b error=%0b, required 0 1", byte_ready, error);
        end
        check_drained("overflow");
    endtask

    task automatic test_gaps();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(8'hC0 + 8'(i), i == 7);
            if (i == 7) break;
            if (i == 3) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check_finish("gaps", 1'b1, 6'd2);
        check_drained("gaps");
    endtask

    task automatic test_reload();
        pulse_start();
        checks++;
        if (core_run !== 1'b0 || done !== 1'b0 || byte_ready !== 1'b1) begin
            errors++;
            $display("FAIL reload_entry: core_run=%0b done=%0b byte_ready=%0b, required 0 0 1", core_run, done, byte_ready);
        end
        for (int i = 0; i < 4; i++) begin
            send_byte(8'h50 + 8'(i), i == 3);
            if (i < 3) begin
                checks++;
                if (core_run !== 1'b0) begin
                    errors++;
                    $display("FAIL reload_core_run: got %0b mid-load, required 0", core_run);
                end
            end
        end
        check_finish("reload", 1'b1, 6'd1);
        check_drained("reload");
    endtask

    task automatic test_reset_midload();
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0);
        checks++;
        if (imem_we !== 1'b1) begin
            errors++;
            $display("FAIL midload_strobe: imem_we=%0b before reset, required 1", imem_we);
        end
        reset = 1'b1;
        #1;
        check_reset_outputs("midload_reset");
        checks++;
        if (exp_q.size() != 1) begin
            errors++;
            $display("FAIL midload_cancelled: %0d writes outstanding, required 1", exp_q.size());
        end
        exp_q.delete();
        #2;
        reset = 1'b0;
        tick();
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(8'h90 + 8'(i), i == 3);
        check_finish("after_reset", 1'b1, 6'd1);
        check_drained("after_reset");
    endtask

    initial begin
        test_reset();
        test_misaligned();
        test_load16();
        test_overflow();
        test_gaps();
        test_reload();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
